// File: rtl/exec_mem_unit.sv
// Decode/execute/memory slice of a single-cycle RV32I core: control decode, ALU, branch
// resolution and word data memory. Define RV_SUBWORD_EN for byte/halfword loads and stores.
module exec_mem_unit #(
  parameter int DMEM_DEPTH = 256,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            reg_write,
  output logic [1:0]      pc_src,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] wb_data
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_f7b5;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_mem_to_reg;
  logic            w_alu_src;
  logic            w_branch;
  logic            w_jump;
  logic            w_jalr;
  logic            w_reg_write;
  logic [3:0]      w_alu_op;
  logic [XLEN-1:0] w_val1;
  logic [XLEN-1:0] w_val2;
  logic            w_taken;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_be;
  logic            w_unused;

  logic [XLEN-1:0] r_mem [DMEM_DEPTH];

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_f7b5   = instr[30];

  // Map funct3 (+ funct7[5] where it distinguishes) onto the ALU operation.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [4:0]             sh;
    logic [XLEN-1:0]        res;
    a_s = a;
    b_s = b;
    sh  = b[4:0];
    case (op)
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = a_s >>> sh;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  res = a + b;
    endcase
    return res;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   t;
    a_s = a;
    b_s = b;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = (a_s < b_s);
      3'b101:  t = (a_s >= b_s);
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jalr       = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = ALU_ADD;
    w_val1       = rs1_data;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = alu_dec(w_funct3, w_f7b5);
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        // Only shifts look at funct7[5]; an immediate with bit 10 set must not turn ADDI into SUB.
        w_alu_op    = alu_dec(w_funct3, w_f7b5 && (w_funct3 == 3'b101));
      end
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_BR: begin
        w_branch = 1'b1;
        w_alu_op = ALU_SUB;
      end
      OP_JAL: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
        w_val1      = pc;
      end
      OP_JALR: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_jalr      = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_LUI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_val1      = '0;
      end
      OP_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_val1      = pc;
      end
      default: ;
    endcase
  end

  assign w_val2     = w_alu_src ? imm : rs2_data;
  assign alu_result = alu_fn(w_alu_op, w_val1, w_val2);
  assign zero       = (alu_result == '0);
  assign w_taken    = w_branch && br_taken(w_funct3, rs1_data, rs2_data);
  assign reg_write  = w_reg_write;

  always_comb begin
    pc_src = 2'b00;
    if (w_jalr)
      pc_src = 2'b10;
    else if (w_jump || w_taken)
      pc_src = 2'b01;
  end

  assign w_idx   = alu_result[AW+1:2];
  assign w_rdata = r_mem[w_idx];

`ifdef RV_SUBWORD_EN
  always_comb begin
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    v_byte = w_rdata[8*alu_result[1:0] +: 8];
    v_half = alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_load = '0;
    if (w_mem_read) begin
      case (w_funct3)
        3'b000:  w_load = {{(XLEN-8){v_byte[7]}}, v_byte};
        3'b001:  w_load = {{(XLEN-16){v_half[15]}}, v_half};
        3'b100:  w_load = {{(XLEN-8){1'b0}}, v_byte};
        3'b101:  w_load = {{(XLEN-16){1'b0}}, v_half};
        default: w_load = w_rdata;
      endcase
    end
  end

  // Narrow store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = rs2_data;
    case (w_funct3)
      3'b000: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end
`else
  assign w_load  = w_mem_read ? w_rdata : '0;
  assign w_be    = 4'hF;
  assign w_wdata = rs2_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  assign wb_data = w_mem_to_reg ? w_load : (w_jump ? pc + 32'd4 : alu_result);

  assign w_unused = ^{instr[31], instr[29:15], instr[11:7], alu_result[1:0],
                      alu_result[XLEN-1:AW+2]};

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: directed vectors push expected outputs, a monitor
// pops and compares on each falling edge. Expectations follow RV_SUBWORD_EN if defined.
module tb_exec_mem_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr, pc, rs1_data, rs2_data, imm;
  logic        reg_write;
  logic [1:0]  pc_src;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [6:0] OP_R    = 7'h33, OP_I    = 7'h13, OP_L   = 7'h03, OP_S   = 7'h23,
                         OP_B    = 7'h63, OP_JAL  = 7'h6F, OP_JALR = 7'h67,
                         OP_LUI  = 7'h37, OP_AUI  = 7'h17, OP_BAD = 7'h7F;
  localparam logic [3:0] M_ALU = 4'h1, M_WB = 4'h2, M_RW = 4'h4, M_PC = 4'h8, M_ALL = 4'hF;

  typedef struct {
    string       nm;
    logic [31:0] alu;
    logic [31:0] wb;
    logic        rw;
    logic [1:0]  pcs;
    logic [3:0]  m;
  } exp_t;

  exp_t q[$];

  exec_mem_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .reg_write(reg_write), .pc_src(pc_src),
    .alu_result(alu_result), .zero(zero), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] op);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] e_alu, input logic [31:0] e_wb, input logic e_rw,
                       input logic [1:0] e_pc, input logic [3:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    instr = ins; pc = p; rs1_data = a; rs2_data = b; imm = im;
    e.nm = nm; e.alu = e_alu; e.wb = e_wb; e.rw = e_rw; e.pcs = e_pc; e.m = m;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[0]) begin
          chk({e.nm, ".alu"}, alu_result, e.alu);
          chk({e.nm, ".zero"}, {31'b0, zero}, {31'b0, (e.alu == 32'd0)});
        end
        if (e.m[1]) chk({e.nm, ".wb"}, wb_data, e.wb);
        if (e.m[2]) chk({e.nm, ".reg_write"}, {31'b0, reg_write}, {31'b0, e.rw});
        if (e.m[3]) chk({e.nm, ".pc_src"}, {30'b0, pc_src}, {30'b0, e.pcs});
      end
    end
  end

  initial begin : stim
    logic [31:0] e_lb, e_lw_lane;
`ifdef RV_SUBWORD_EN
    e_lb = 32'hFFFF_FFAB; e_lw_lane = 32'h0000_AB00;
`else
    e_lb = 32'h0000_00AB; e_lw_lane = 32'h0000_00AB;
`endif
    rst = 1'b1; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;

    apply("rst_lw",  mk(0, 2, OP_L), 0, 32'h10, 0, 4, 32'h14, 0, 1'b1, 2'b00, M_ALL);
    @(negedge clk); #1 rst = 1'b0;

    apply("add",      32'h002081B3, 0, 5, 7, 0, 12, 12, 1'b1, 2'b00, M_ALL);
    apply("add_wrap", mk(0, 0, OP_R), 0, 32'hFFFF_FFFF, 2, 0, 1, 1, 1'b1, 2'b00, M_ALL);
    apply("sub_zero", mk(7'h20, 0, OP_R), 0, 32'h1234, 32'h1234, 0, 0, 0, 1'b1, 2'b00, M_ALL);
    apply("srai", mk(7'h20, 5, OP_I), 0, 32'h8000_0000, 0, 32'h404,
          32'hF800_0000, 32'hF800_0000, 1'b1, 2'b00, M_ALL);
    apply("srl", mk(0, 5, OP_R), 0, 32'h8000_0000, 4, 0, 32'h0800_0000, 32'h0800_0000,
          1'b1, 2'b00, M_ALL);
    apply("sll_mask", mk(0, 1, OP_R), 0, 1, 33, 0, 2, 2, 1'b1, 2'b00, M_ALL);
    apply("slt",  mk(0, 2, OP_R), 0, 32'hFFFF_FFFF, 1, 0, 1, 1, 1'b1, 2'b00, M_ALL);
    apply("sltu", mk(0, 3, OP_R), 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b1, 2'b00, M_ALL);
    apply("xor",  mk(0, 4, OP_R), 0, 32'hF0F0, 32'h0FF0, 0, 32'hFF00, 32'hFF00, 1'b1, 2'b00, M_ALL);
    apply("or",   mk(0, 6, OP_R), 0, 32'hF000, 32'h000F, 0, 32'hF00F, 32'hF00F, 1'b1, 2'b00, M_ALL);
    apply("and",  mk(0, 7, OP_R), 0, 32'hFF00, 32'h0FF0, 0, 32'h0F00, 32'h0F00, 1'b1, 2'b00, M_ALL);
    apply("addi_f7", mk(7'h20, 0, OP_I), 0, 10, 99, 3, 13, 13, 1'b1, 2'b00, M_ALL);
    apply("illegal", mk(0, 0, OP_BAD), 0, 5, 6, 100, 11, 11, 1'b0, 2'b00, M_ALL);

    apply("sw", mk(0, 2, OP_S), 0, 32'h10, 32'hDEAD_BEEF, 4, 32'h14, 0, 1'b0, 2'b00,
          M_ALU | M_RW | M_PC);
    apply("lw", mk(0, 2, OP_L), 0, 32'h10, 0, 4, 32'h14, 32'hDEAD_BEEF, 1'b1, 2'b00, M_ALL);

    apply("beq",  mk(0, 0, OP_B), 0, 3, 3, 0, 0, 0, 1'b0, 2'b01, M_RW | M_PC);
    apply("bne",  mk(0, 1, OP_B), 0, 3, 3, 0, 0, 0, 1'b0, 2'b00, M_RW | M_PC);
    apply("blt",  mk(0, 4, OP_B), 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b0, 2'b01, M_PC);
    apply("bge",  mk(0, 5, OP_B), 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b0, 2'b00, M_PC);
    apply("bltu", mk(0, 6, OP_B), 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 2'b01, M_PC);
    apply("bgeu", mk(0, 7, OP_B), 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b0, 2'b01, M_PC);
    apply("b010", mk(0, 2, OP_B), 0, 3, 3, 0, 0, 0, 1'b0, 2'b00, M_PC);

    apply("jal",  mk(0, 0, OP_JAL), 32'h100, 0, 0, 32'h40, 0, 32'h104, 1'b1, 2'b01,
          M_WB | M_RW | M_PC);
    apply("jalr", mk(0, 0, OP_JALR), 32'h200, 32'h40, 0, 8, 0, 32'h204, 1'b1, 2'b10,
          M_WB | M_RW | M_PC);
    apply("lui",  mk(0, 0, OP_LUI), 0, 32'hFFFF, 0, 32'h1234_5000,
          32'h1234_5000, 32'h1234_5000, 1'b1, 2'b00, M_ALL);
    apply("auipc", mk(0, 0, OP_AUI), 32'h1000, 5, 0, 32'h2000, 32'h3000, 32'h3000,
          1'b1, 2'b00, M_ALL);

    apply("sw_wrap", mk(0, 2, OP_S), 0, 32'h400, 32'h55, 8, 32'h408, 0, 1'b0, 2'b00,
          M_ALU | M_RW | M_PC);
    apply("lw_wrap", mk(0, 2, OP_L), 0, 0, 0, 8, 8, 32'h55, 1'b1, 2'b00, M_ALL);

    apply("sb",  mk(0, 0, OP_S), 0, 32'h20, 32'hAB, 1, 32'h21, 0, 1'b0, 2'b00, M_ALU | M_RW);
    apply("lb",  mk(0, 0, OP_L), 0, 32'h20, 0, 1, 32'h21, e_lb, 1'b1, 2'b00, M_ALL);
    apply("lw_lane", mk(0, 2, OP_L), 0, 32'h20, 0, 0, 32'h20, e_lw_lane, 1'b1, 2'b00, M_ALL);
    apply("lbu", mk(0, 4, OP_L), 0, 32'h20, 0, 1, 32'h21, 32'hAB, 1'b1, 2'b00, M_ALL);

    // Asynchronous reset pulse placed between clock edges.
    @(negedge clk); #2 rst = 1'b1; #2 rst = 1'b0;
    apply("lw_after_rst",  mk(0, 2, OP_L), 0, 32'h10, 0, 4, 32'h14, 0, 1'b1, 2'b00, M_ALL);
    apply("lw_after_rst2", mk(0, 2, OP_L), 0, 32'h20, 0, 0, 32'h20, 0, 1'b1, 2'b00, M_ALL);

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
